// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the count-driven PWM block.
// FSM states, default widths and the 100% duty constant.
package pwm_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } pwm_state_e;

  localparam int CNT_W_DEF      = 6;
  localparam int PERIOD_MAX_DEF = 15;
  localparam int PCNT_W_DEF     = 8;
  // A duty equal to the period length keeps the output high all period.
  localparam int DUTY_FULL      = PERIOD_MAX_DEF + 1;

endpackage

// File: rtl/pwm_from_count_count_seq_check.sv
// count_seq_check: combinational sequence check of the incoming count.
// expected is the value the count must take this cycle given last cycle's
// count; mismatch flags any other value (including a hold or an out-of-range
// count); wrap_seen marks the legal PERIOD_MAX -> 0 step.
module count_seq_check
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PERIOD_MAX = PERIOD_MAX_DEF
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] count_q,
  output logic [CNT_W-1:0] expected,
  output logic             mismatch,
  output logic             wrap_seen
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_MAX);

  // Next legal count value and the resulting sequence verdict.
  always_comb begin
    expected  = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    mismatch  = (count != expected) || (count > LAST);
    wrap_seen = (count_q == LAST) && (count == '0);
  end

endmodule

// File: rtl/pwm_from_count.sv
// pwm_from_count: PWM generator driven by an external wrap-at-PERIOD_MAX
// counter. Duty is loaded through a valid/ready shadow register and is only
// promoted to the active duty on a period wrap. Breaks in the count sequence
// set a sticky error and force a resync on the next count==0.
//
// Handshake: a duty value transfers on a rising clk edge where
// duty_valid && duty_ready. duty_ready is high whenever the shadow register
// is empty and rst is low; duty_valid/duty_in must stay stable until the
// transfer happens.
//
// Optional build macro: PWM_FORMAL_EN adds embedded assertions (no logic
// change).
module pwm_from_count
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PERIOD_MAX = PERIOD_MAX_DEF,
  parameter int PCNT_W     = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              wrap_pulse,
  output logic              seq_err,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PERIOD_MAX + 1);

  pwm_state_e       state;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] duty_active;
  logic [CNT_W-1:0] shadow;
  logic             pending;

  logic [CNT_W-1:0] expected;
  logic             mismatch;
  logic             wrap_seen;
  logic             wrap_event;
  logic             accept;
  logic [CNT_W-1:0] duty_clamped;
  logic [CNT_W-1:0] duty_next;

  count_seq_check #(
    .CNT_W      (CNT_W),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_seq (
    .count     (count),
    .count_q   (count_q),
    .expected  (expected),
    .mismatch  (mismatch),
    .wrap_seen (wrap_seen)
  );

  assign duty_ready = !pending && !rst;
  assign accept     = duty_valid && duty_ready;
  assign state_dbg  = state;

  // Period boundary: a clean PERIOD_MAX -> 0 step while running
  // (expected==0 is exactly the boundary slot of the sequence).
  always_comb begin
    wrap_event   = (state == RUN) && !mismatch && wrap_seen && (expected == '0);
    duty_clamped = (duty_in > FULL) ? FULL : duty_in;
    // On a wrap the pre-edge shadow becomes the duty for the new period,
    // so the count==0 compare already sees the new value.
    duty_next    = (wrap_event && pending) ? shadow : duty_active;
  end

  // Sequencing FSM with registered PWM, wrap pulse, error flag and period count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      count_q    <= '0;
      pwm_out    <= 1'b0;
      wrap_pulse <= 1'b0;
      seq_err    <= 1'b0;
      period_cnt <= '0;
    end else begin
      count_q    <= count;
      wrap_pulse <= wrap_event;
      if (wrap_event && (period_cnt != '1)) begin
        period_cnt <= period_cnt + PCNT_W'(1);
      end
      case (state)
        SYNC: begin
          pwm_out <= 1'b0;
          if (count == '0) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (mismatch) begin
            state   <= ERR;
            seq_err <= 1'b1;
            pwm_out <= 1'b0;
          end else begin
            pwm_out <= (count < duty_next);
          end
        end
        ERR: begin
          pwm_out <= 1'b0;
          state   <= SYNC;
        end
        default: begin
          pwm_out <= 1'b0;
          state   <= SYNC;
        end
      endcase
    end
  end

  // Duty shadow/active registers: load on handshake, promote on wrap only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      duty_active <= duty_next;
      if (accept) begin
        shadow  <= duty_clamped;
        pending <= 1'b1;
      end else if (wrap_event) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef PWM_FORMAL_EN
  a_count_q_range : assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (count_q <= LAST));
  a_wrap_single : assert property (@(posedge clk) disable iff (rst)
    wrap_pulse |=> !wrap_pulse);
  a_ready_empty : assert property (@(posedge clk) disable iff (rst)
    duty_ready |-> !pending);
  a_pwm_run_only : assert property (@(posedge clk) disable iff (rst)
    pwm_out |-> ($past(state) == RUN));
  a_duty_range : assert property (@(posedge clk) disable iff (rst)
    duty_active <= FULL);
  a_count_step : assert property (@(posedge clk) disable iff (rst)
    ((state == RUN) && !mismatch) |->
      ((count == count_q + CNT_W'(1)) || ((count_q == LAST) && (count == '0))));
`endif

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed bench for pwm_from_count: a spec-level model predicts the outputs
// for every driven clock; literal expectations pin key points of the model.
module tb_pwm_from_count;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] count;
  logic [5:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap_pulse;
  logic       seq_err;
  logic [7:0] period_cnt;
  logic [1:0] state_dbg;

  pwm_from_count dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .seq_err    (seq_err),
    .period_cnt (period_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];  // {ready, pwm, wrap, seq_err, period_cnt}
  int high_cnt = 0;
  int src      = 0;

  // Model: phase 0 = waiting for count 0, 1 = tracking, 2 = error recovery.
  int m_phase, m_prev, m_duty, m_shadow, m_pend, m_periods, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_duty = 0; m_shadow = 0;
    m_pend = 0; m_periods = 0; m_err = 0;
  endtask

  // Predict outputs after the coming edge from the spec's rules.
  task automatic model_step(input int c, input int v, input int din);
    int pwm, wrap, take, next_phase;
    pwm = 0; wrap = 0;
    take = (v != 0) && (m_pend == 0);
    next_phase = m_phase;
    if (m_phase == 0) begin
      if (c == 0) next_phase = 1;
    end else if (m_phase == 2) begin
      next_phase = 0;
    end else begin
      if (c != (m_prev + 1) % 16) begin
        m_err = 1;
        next_phase = 2;
      end else begin
        if (c == 0) begin
          wrap = 1;
          if (m_periods < 255) m_periods++;
          if (m_pend != 0) begin
            m_duty = m_shadow;
            m_pend = 0;
          end
        end
        pwm = (c < m_duty) ? 1 : 0;
      end
    end
    if (take != 0) begin
      m_shadow = (din > 16) ? 16 : din;
      m_pend = 1;
    end
    m_prev = c;
    m_phase = next_phase;
    exp_q.push_back({(m_pend == 0) ? 1'b1 : 1'b0, pwm[0], wrap[0], m_err[0], 8'(m_periods)});
  endtask

  // ---------------- driver tasks ----------------
  // Starts just after a falling edge; ends just after the next falling edge.
  task automatic tick(input int v, input int din, input int c);
    logic [11:0] e;
    count = 6'(c); duty_valid = v[0]; duty_in = 6'(din);
    model_step(c, v, din);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("duty_ready", 32'(duty_ready), 32'(e[11]));
      check("pwm_out", 32'(pwm_out), 32'(e[10]));
      check("wrap_pulse", 32'(wrap_pulse), 32'(e[9]));
      check("seq_err", 32'(seq_err), 32'(e[8]));
      check("period_cnt", 32'(period_cnt), 32'(e[7:0]));
    end
    if (pwm_out === 1'b1) high_cnt++;
    #1;
    duty_valid = 1'b0;
  endtask

  task automatic tick_src(input int v, input int din);
    int c;
    c = src;
    src = (src == 15) ? 0 : src + 1;
    tick(v, din, c);
  endtask

  // Load a duty mid-period, then measure high clocks over the next period.
  task automatic load_measure(input int din, input int exp_high);
    int base;
    tick_src(0, 0);
    tick_src(1, din);
    check("ready_after_load", 32'(duty_ready), 32'd0);
    repeat (14) tick_src(0, 0);
    base = high_cnt;
    tick_src(0, 0);
    check("ready_after_wrap", 32'(duty_ready), 32'd1);
    repeat (15) tick_src(0, 0);
    check("high_clocks", 32'(high_cnt - base), 32'(exp_high));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b1; count = '0; duty_valid = 1'b0; duty_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(duty_ready), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_period_cnt", 32'(period_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(duty_ready), 32'd1);

    // Sync on count 0, first wrap 16 clocks later.
    src = 0;
    repeat (17) tick_src(0, 0);
    check("first_wrap_pulse", 32'(wrap_pulse), 32'd1);
    check("first_period_cnt", 32'(period_cnt), 32'd1);
    repeat (16) tick_src(0, 0);
    check("second_period_cnt", 32'(period_cnt), 32'd2);
    repeat (15) tick_src(0, 0);

    // Duty loads: 4, full, clamped, zero.
    load_measure(4, 4);
    load_measure(16, 16);
    load_measure(40, 16);
    load_measure(0, 0);

    // Accept on the wrap edge: applies only at the following wrap.
    base = high_cnt;
    tick_src(1, 8);
    check("ready_wrap_accept", 32'(duty_ready), 32'd0);
    repeat (15) tick_src(0, 0);
    check("wrap_accept_old_duty", 32'(high_cnt - base), 32'd0);
    base = high_cnt;
    repeat (16) tick_src(0, 0);
    check("wrap_accept_new_duty", 32'(high_cnt - base), 32'd8);

    // Sequence break 5 -> 7 with a pending duty of 3.
    tick_src(0, 0);
    tick_src(0, 0);
    tick_src(1, 3);
    repeat (3) tick_src(0, 0);
    src = 7;
    tick_src(0, 0);
    check("err_seq_err", 32'(seq_err), 32'd1);
    check("err_pwm", 32'(pwm_out), 32'd0);
    repeat (9) tick_src(0, 0);
    check("pending_kept", 32'(duty_ready), 32'd0);
    repeat (15) tick_src(0, 0);
    base = high_cnt;
    repeat (16) tick_src(0, 0);
    check("duty_after_resync", 32'(high_cnt - base), 32'd3);
    check("seq_err_sticky", 32'(seq_err), 32'd1);

    // Stuck count: 0,1,1 is an error, then resync.
    tick_src(0, 0);
    tick_src(0, 0);
    tick(0, 0, 1);
    src = 2;
    repeat (14) tick_src(0, 0);

    // Saturate the period counter and hold it over one more wrap.
    repeat (256 * 16) tick_src(0, 0);
    check("period_cnt_sat", 32'(period_cnt), 32'd255);
    repeat (16) tick_src(0, 0);
    check("period_cnt_hold", 32'(period_cnt), 32'd255);

    // Asynchronous reset mid-period.
    repeat (5) tick_src(0, 0);
    rst = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_wrap", 32'(wrap_pulse), 32'd0);
    check("async_rst_seq_err", 32'(seq_err), 32'd0);
    check("async_rst_period_cnt", 32'(period_cnt), 32'd0);
    check("async_rst_ready", 32'(duty_ready), 32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    src = 0;
    repeat (20) tick_src(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
